mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the pipeline's instruction-fetch (IF) port and data-memory (DM) port.
- Serialises accesses with a req/ack handshake. Drives stall outputs back to the hazard logic while a requester waits.
- DM has priority. An aging counter bounds how long IF can be starved.
- Sits between the pipeline core and the memory model, replacing the separate instruction/data memory paths.

Parameters:
MEM_LAT, 1, memory read latency in cycles from the edge that samples mem_en to mem_rdata valid (1..7)
MAX_WAIT, 2, lost arbitrations after which a waiting IF request beats DM; 0 = strict DM priority, no aging
AW, 10, byte-address width

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous reset, active-high
if_req  in  1  IF read request; held with if_addr stable until if_ack
if_addr  in  AW  IF byte address
if_ack  out  1  one-cycle pulse; if_rdata valid in the same cycle
if_rdata  out  32  fetched word
dm_req  in  1  DM request; held with its fields stable until dm_ack
dm_wen  in  1  1 = write, 0 = read
dm_wsize  in  2  access size, passed through (00 byte, 01 half, 10 word)
dm_addr  in  AW  DM byte address
dm_wdata  in  32  write data
dm_ack  out  1  one-cycle completion pulse
dm_rdata  out  32  read data, valid with dm_ack on reads
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_wsize  out  2  memory access size
mem_addr  out  AW  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data
if_stall  out  1  if_req & ~if_ack (combinational)
dm_stall  out  1  dm_req & ~dm_ack (combinational)
busy  out  1  state != IDLE

Behaviour:
- Reset: all of the following go to 0 immediately on rst: state=IDLE, mem_en, mem_we, mem_wsize, mem_addr, mem_wdata, if_ack, dm_ack, if_rdata, dm_rdata, wait_cnt, lat_cnt, owner.
- Reset mid-access: the in-flight access is abandoned and no ack is issued. A requester still holding req is re-arbitrated after rst falls.
- States:
  - IDLE: no access in flight.
  - ISSUE: mem_en=1 for exactly one cycle.
  - WAIT: lat_cnt counts MEM_LAT cycles.
  - RESP: ack high for one cycle.
- Transitions:
  - IDLE→ISSUE on the edge where any req is sampled.
  - ISSUE→WAIT.
  - WAIT→RESP on the edge where lat_cnt==MEM_LAT; mem_rdata is captured into the owner's rdata register at that edge.
  - RESP→ISSUE if a non-owner req is pending, else RESP→IDLE.
- Arbitration happens at edges in IDLE or RESP:
  - In RESP, the current owner's req is ignored for that edge, because the requester only drops req after seeing ack.
  - Both requesting: grant DM, unless MAX_WAIT>0 and wait_cnt>=MAX_WAIT, in which case grant IF.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) on each arbitration edge where IF requests and DM is granted.
  - Clears when IF is granted.
  - Holds otherwise.
- mem_* fields are registered from the granted requester at the arbitration edge and held until the next grant. mem_we=dm_wen for DM grants and 0 for IF grants.
- Latency for an uncontended request first sampled at edge E0:
  - mem_en high in cycle E0..E1.
  - ack high in cycle E(MEM_LAT+1)..E(MEM_LAT+2).
  - Total: MEM_LAT+2 edges from sampling to the ack cycle.
  - Back-to-back accesses from alternating requesters: one access per MEM_LAT+2 cycles.
- Writes: same timing. dm_ack is issued and dm_rdata holds its previous value.
- Simultaneous new requests from both ports in RESP of a third-party owner cannot occur (only two requesters). In RESP, the other port's pending request is granted without an idle gap.
- Request dropped before ack: protocol violation. The access completes and the ack is still pulsed.
- Addresses are not alignment-checked; they are passed through unchanged.

Test Plan:
- Reset, then IF-only read at if_addr=0x010 with memory word 0x8C010004, MEM_LAT=1 → mem_en pulses in cycle 1, if_ack and if_rdata=0x8C010004 in cycle 3, busy high for cycles 1–3, if_stall high for cycles 0–2.
- DM write dm_addr=0x004, dm_wdata=0xDEADBEEF, dm_wsize=10 → mem_we=1 with mem_en, dm_ack in cycle 3, dm_rdata unchanged. A subsequent DM read of 0x004 returns 0xDEADBEEF.
- IF and DM requesting continuously, MAX_WAIT=2 → grant order DM, DM, IF, DM, DM, IF; wait_cnt sequence 1, 2, 0; no ack gaps beyond MEM_LAT+2.
- MAX_WAIT=0 with both requesting continuously → only DM is granted; if_stall stays 1; wait_cnt stays 0.
- MEM_LAT=3, IF read → ack 5 edges after sampling; a DM request raised during WAIT is granted at the RESP edge, mem_en in the cycle immediately after the IF ack.
- rst asserted mid-WAIT of a DM read → all outputs 0 immediately, no dm_ack. After rst falls with dm_req still held, the access restarts and acks MEM_LAT+2 edges later.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle between the pipeline's IF/DM ports, the shared memory and the arbiter.
// The arbiter takes the slave view; the core/memory side takes the master view.
interface mem_port_arbiter_if #(
  parameter int AW = 10
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [31:0]   if_rdata;
  logic          dm_req;
  logic          dm_wen;
  logic [1:0]    dm_wsize;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic          dm_ack;
  logic [31:0]   dm_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [1:0]    mem_wsize;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          if_stall;
  logic          dm_stall;
  logic          busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_wen, dm_wsize, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata,
    output mem_en, mem_we, mem_wsize, mem_addr, mem_wdata,
    output if_stall, dm_stall, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_wen, dm_wsize, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata,
    input  mem_en, mem_we, mem_wsize, mem_addr, mem_wdata,
    input  if_stall, dm_stall, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between IF and DM ports.
// DM wins contention; an aging counter lets a repeatedly losing IF request through.
module mem_port_arbiter #(
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 2,
  parameter int AW       = 10
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam int            WW        = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [AW-1:0] ZERO_ADDR = '0;
  localparam logic [1:0]    WORD      = 2'b10;

  logic [1:0]    state;
  logic          owner;     // 1 = DM owns the access in flight
  logic [WW-1:0] wait_cnt;
  logic [2:0]    lat_cnt;

  logic arb, if_cand, dm_cand, age_hit, grant, gnt_dm;

  // In RESP the owner still holds req until it sees ack, so its req is stale there.
  always_comb begin
    arb     = (state == IDLE) || (state == RESP);
    if_cand = bus.if_req && !((state == RESP) && !owner);
    dm_cand = bus.dm_req && !((state == RESP) && owner);
    age_hit = (MAX_WAIT > 0) && (int'(wait_cnt) >= MAX_WAIT);
    grant   = arb && (if_cand || dm_cand);
    gnt_dm  = dm_cand && !(if_cand && age_hit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= 1'b0;
      wait_cnt      <= '0;
      lat_cnt       <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_wsize <= '0;
      bus.mem_addr  <= ZERO_ADDR;
      bus.mem_wdata <= '0;
      bus.if_ack    <= 1'b0;
      bus.dm_ack    <= 1'b0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
    end else begin
      bus.mem_en <= 1'b0;
      bus.if_ack <= 1'b0;
      bus.dm_ack <= 1'b0;
      case (state)
        ISSUE: begin
          state   <= WAIT;
          lat_cnt <= 3'd1;
        end
        WAIT: begin
          if (lat_cnt == 3'(MEM_LAT)) begin
            state <= RESP;
            if (owner) begin
              bus.dm_ack <= 1'b1;
              if (!bus.mem_we) bus.dm_rdata <= bus.mem_rdata;
            end else begin
              bus.if_ack   <= 1'b1;
              bus.if_rdata <= bus.mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        default: state <= grant ? ISSUE : IDLE;
      endcase

      if (grant) begin
        owner         <= gnt_dm;
        bus.mem_en    <= 1'b1;
        bus.mem_we    <= gnt_dm && bus.dm_wen;
        bus.mem_wsize <= gnt_dm ? bus.dm_wsize : WORD;
        bus.mem_addr  <= gnt_dm ? bus.dm_addr : bus.if_addr;
        bus.mem_wdata <= gnt_dm ? bus.dm_wdata : '0;
        if (!gnt_dm)
          wait_cnt <= '0;
        else if (if_cand && (int'(wait_cnt) < MAX_WAIT))
          wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  assign bus.if_stall = bus.if_req & ~bus.if_ack;
  assign bus.dm_stall = bus.dm_req & ~bus.dm_ack;
  assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: dut_a (MEM_LAT=1, MAX_WAIT=2) and dut_b (MEM_LAT=3, MAX_WAIT=0),
// each with its own behavioural memory.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(10)) ia ();
  mem_port_arbiter_if #(.AW(10)) ib ();

  mem_port_arbiter #(.MEM_LAT(1), .MAX_WAIT(2), .AW(10)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  mem_port_arbiter #(.MEM_LAT(3), .MAX_WAIT(0), .AW(10)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  // Memory models: read data only valid exactly MEM_LAT cycles after the sampled strobe.
  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic [31:0] rd_a;
  logic [31:0] rd_b [0:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_a[4] <= 32'h8C010004;
      mem_a[8] <= 32'h11112222;
    end else if (ia.mem_en && ia.mem_we) begin
      mem_a[ia.mem_addr[9:2]] <= ia.mem_wdata;
    end
    rd_a <= (ia.mem_en && !ia.mem_we) ? mem_a[ia.mem_addr[9:2]] : 32'hBAD0BAD0;
  end
  assign ia.mem_rdata = rd_a;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_b[4] <= 32'hCAFE0001;
      mem_b[5] <= 32'h0B0B0B0B;
      mem_b[6] <= 32'h5A5A1234;
    end else if (ib.mem_en && ib.mem_we) begin
      mem_b[ib.mem_addr[9:2]] <= ib.mem_wdata;
    end
    rd_b[0] <= (ib.mem_en && !ib.mem_we) ? mem_b[ib.mem_addr[9:2]] : 32'hBAD0BAD0;
    rd_b[1] <= rd_b[0];
    rd_b[2] <= rd_b[1];
  end
  assign ib.mem_rdata = rd_b[2];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Single uncontended access on dut_a; cycle 0 is the cycle the request is raised.
  task automatic acc_a(input string tag, input bit is_dm, input bit wen, input logic [9:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd);
    if (is_dm) begin
      ia.dm_req = 1'b1; ia.dm_wen = wen; ia.dm_wsize = 2'b10; ia.dm_addr = addr; ia.dm_wdata = wd;
    end else begin
      ia.if_req = 1'b1; ia.if_addr = addr;
    end
    for (int c = 0; c < 5; c++) begin
      #1;
      chkb({tag, "_mem_en"}, ia.mem_en, c == 1);
      chkb({tag, "_busy"}, ia.busy, (c >= 1) && (c <= 3));
      chkb({tag, "_ack"}, is_dm ? ia.dm_ack : ia.if_ack, c == 3);
      chkb({tag, "_stall"}, is_dm ? ia.dm_stall : ia.if_stall, c <= 2);
      if (c == 1) begin
        chk({tag, "_mem_addr"}, 32'(ia.mem_addr), 32'(addr));
        chkb({tag, "_mem_we"}, ia.mem_we, is_dm && wen);
        chk({tag, "_mem_wsize"}, 32'(ia.mem_wsize), 32'd2);
        if (wen) chk({tag, "_mem_wdata"}, ia.mem_wdata, wd);
      end
      if (c == 3) begin
        chk({tag, "_rdata"}, is_dm ? ia.dm_rdata : ia.if_rdata, exp_rd);
        if (is_dm) ia.dm_req = 1'b0; else ia.if_req = 1'b0;
      end
      step();
    end
  endtask

  // Both ports request from IDLE; a losing IF withdraws so the next round re-arbitrates in IDLE.
  task automatic round_a(input string tag, input bit exp_dm, input int exp_wait);
    ia.if_req = 1'b1; ia.if_addr = 10'h020;
    ia.dm_req = 1'b1; ia.dm_wen = 1'b0; ia.dm_wsize = 2'b10; ia.dm_addr = 10'h004;
    step();
    chkb({tag, "_en"}, ia.mem_en, 1'b1);
    chk({tag, "_grant"}, 32'(ia.mem_addr), exp_dm ? 32'h004 : 32'h020);
    chk({tag, "_wait"}, 32'(dut_a.wait_cnt), 32'(exp_wait));
    if (exp_dm) ia.if_req = 1'b0;
    step();
    step();
    if (exp_dm) begin
      chkb({tag, "_dm_ack"}, ia.dm_ack, 1'b1);
      chk({tag, "_dm_rdata"}, ia.dm_rdata, 32'hDEADBEEF);
      ia.dm_req = 1'b0;
      step();
      chkb({tag, "_idle"}, ia.busy, 1'b0);
    end else begin
      chkb({tag, "_if_ack"}, ia.if_ack, 1'b1);
      chk({tag, "_if_rdata"}, ia.if_rdata, 32'h11112222);
      ia.if_req = 1'b0;
      step();
      chkb({tag, "_dm_nogap"}, ia.mem_en, 1'b1);
      chk({tag, "_dm_addr"}, 32'(ia.mem_addr), 32'h004);
      chk({tag, "_wait_after"}, 32'(dut_a.wait_cnt), 32'd0);
      step();
      step();
      chkb({tag, "_dm_ack"}, ia.dm_ack, 1'b1);
      chk({tag, "_dm_rdata"}, ia.dm_rdata, 32'hDEADBEEF);
      ia.dm_req = 1'b0;
      step();
      chkb({tag, "_idle"}, ia.busy, 1'b0);
    end
  endtask

  // Contended round on dut_b: aging disabled, so DM always wins.
  task automatic round_b(input string tag);
    ib.if_req = 1'b1; ib.if_addr = 10'h014;
    ib.dm_req = 1'b1; ib.dm_wen = 1'b0; ib.dm_wsize = 2'b10; ib.dm_addr = 10'h010;
    #1;
    chkb({tag, "_if_stall0"}, ib.if_stall, 1'b1);
    step();
    chkb({tag, "_en"}, ib.mem_en, 1'b1);
    chk({tag, "_grant"}, 32'(ib.mem_addr), 32'h010);
    chk({tag, "_wait"}, 32'(dut_b.wait_cnt), 32'd0);
    chkb({tag, "_if_stall1"}, ib.if_stall, 1'b1);
    ib.if_req = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      step();
      chkb({tag, "_dm_ack"}, ib.dm_ack, c == 5);
    end
    chk({tag, "_dm_rdata"}, ib.dm_rdata, 32'hCAFE0001);
    ib.dm_req = 1'b0;
    step();
    chkb({tag, "_idle"}, ib.busy, 1'b0);
  endtask

  initial begin
    ia.if_req = 1'b0; ia.if_addr = '0; ia.dm_req = 1'b0; ia.dm_wen = 1'b0;
    ia.dm_wsize = '0; ia.dm_addr = '0; ia.dm_wdata = '0;
    ib.if_req = 1'b0; ib.if_addr = '0; ib.dm_req = 1'b0; ib.dm_wen = 1'b0;
    ib.dm_wsize = '0; ib.dm_addr = '0; ib.dm_wdata = '0;
    step();
    step();
    chkb("rst_mem_en", ia.mem_en, 1'b0);
    chkb("rst_busy", ia.busy, 1'b0);
    chkb("rst_if_ack", ia.if_ack, 1'b0);
    chkb("rst_dm_ack", ia.dm_ack, 1'b0);
    chk("rst_if_rdata", ia.if_rdata, 32'h0);
    chk("rst_mem_addr", 32'(ia.mem_addr), 32'h0);
    chk("rst_wait_cnt", 32'(dut_a.wait_cnt), 32'h0);
    chkb("rst_b_busy", ib.busy, 1'b0);
    rst = 1'b0;

    acc_a("if_rd", 1'b0, 1'b0, 10'h010, 32'h0, 32'h8C010004);
    acc_a("dm_wr", 1'b1, 1'b1, 10'h004, 32'hDEADBEEF, 32'h0);
    acc_a("dm_rd", 1'b1, 1'b0, 10'h004, 32'h0, 32'hDEADBEEF);
    chk("if_rdata_kept", ia.if_rdata, 32'h8C010004);

    round_a("age1", 1'b1, 1);
    round_a("age2", 1'b1, 2);
    round_a("age3", 1'b0, 0);

    round_b("noage1");
    round_b("noage2");

    // MEM_LAT=3 IF read with a DM request arriving during WAIT
    ib.if_req = 1'b1; ib.if_addr = 10'h010;
    #1;
    chkb("lat3_stall0", ib.if_stall, 1'b1);
    step();
    chkb("lat3_en", ib.mem_en, 1'b1);
    step();
    ib.dm_req = 1'b1; ib.dm_wen = 1'b0; ib.dm_addr = 10'h014;
    step();
    step();
    chkb("lat3_no_early_ack", ib.if_ack, 1'b0);
    step();
    chkb("lat3_if_ack", ib.if_ack, 1'b1);
    chk("lat3_if_rdata", ib.if_rdata, 32'hCAFE0001);
    chkb("lat3_dm_stall", ib.dm_stall, 1'b1);
    ib.if_req = 1'b0;
    step();
    chkb("lat3_dm_en", ib.mem_en, 1'b1);
    chk("lat3_dm_addr", 32'(ib.mem_addr), 32'h014);
    chkb("lat3_if_ack_off", ib.if_ack, 1'b0);
    step(); step(); step(); step();
    chkb("lat3_dm_ack", ib.dm_ack, 1'b1);
    chk("lat3_dm_rdata", ib.dm_rdata, 32'h0B0B0B0B);
    ib.dm_req = 1'b0;
    step();
    chkb("lat3_idle", ib.busy, 1'b0);

    // Reset in the middle of a DM read's WAIT phase
    ib.dm_req = 1'b1; ib.dm_wen = 1'b0; ib.dm_addr = 10'h018;
    step();
    chkb("mrst_en", ib.mem_en, 1'b1);
    step();
    rst = 1'b1;
    #1;
    chkb("mrst_busy", ib.busy, 1'b0);
    chkb("mrst_mem_en", ib.mem_en, 1'b0);
    chkb("mrst_dm_ack", ib.dm_ack, 1'b0);
    chk("mrst_dm_rdata", ib.dm_rdata, 32'h0);
    chk("mrst_mem_addr", 32'(ib.mem_addr), 32'h0);
    chk("mrst_a_if_rdata", ia.if_rdata, 32'h0);
    chk("mrst_a_dm_rdata", ia.dm_rdata, 32'h0);
    step();
    chkb("mrst_hold_ack", ib.dm_ack, 1'b0);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      chkb("mrst_re_en", ib.mem_en, c == 1);
      chkb("mrst_re_ack", ib.dm_ack, c == 5);
      chkb("mrst_re_busy", ib.busy, c >= 1);
      if (c == 5) begin
        chk("mrst_re_rdata", ib.dm_rdata, 32'h5A5A1234);
        ib.dm_req = 1'b0;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
